// File: rtl/bcd_scan_display.sv
// bcd_scan_display: multiplexed 7-segment scan driver with frame-synchronous digit capture
module bcd_scan_display #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  blank_lz,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  // Segment patterns indexed by BCD code; codes 10-15 show a dash.
  localparam logic [111:0] SEG_LUT = {{6{7'h40}}, 7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_q, snap_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d, lz;
  logic                cap_q, cap_d, ft_q, ft_d, tick, last, acc;
  logic [3:0]          cur;

  // Next-state: prescaler, digit index, frame snapshot and registered display outputs.
  // lz[i] is set when snapshot digits DIGITS-1 down to i are all zero.
  always_comb begin
    tick   = en & (cnt_q == CW'(REFRESH_DIV - 1));
    last   = idx_q == IW'(DIGITS - 1);
    acc    = 1'b1;
    lz     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc   = acc & (snap_q[4*i +: 4] == 4'd0);
      lz[i] = acc;
    end
    cur    = snap_q[{idx_q, 2'b00} +: 4];
    cnt_d  = !en ? cnt_q : tick ? '0 : cnt_q + CW'(1);
    idx_d  = !tick ? idx_q : last ? '0 : idx_q + IW'(1);
    snap_d = (tick && last) ? bcd_in : snap_q;
    an_d   = en ? DIGITS'(1) << idx_q : an_q;
    seg_d  = !en ? seg_q
           : (blank_lz && idx_q != '0 && lz[idx_q]) ? 7'h00
           : SEG_LUT[int'(cur) * 7 +: 7];
    cap_d  = en ? (tick & last) : cap_q;
    ft_d   = en & cap_q;
  end

  // State registers; reset clears the display immediately without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      snap_q <= '0;
      seg_q  <= '0;
      an_q   <= '0;
      cap_q  <= 1'b0;
      ft_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      cap_q  <= cap_d;
      ft_q   <= ft_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = ft_q;
endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: scoreboard bench comparing the scan driver against a frame-arithmetic model
module tb_bcd_scan_display;
  localparam int D = 4;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  bcd_scan_display #(.DIGITS(D), .REFRESH_DIV(R)) dut (
    .clk(clk), .rst(rst), .en(en), .blank_lz(blank_lz), .bcd_in(bcd_in),
    .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  logic [6:0]  dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  logic [11:0] sb [$];
  int          checks = 0;
  int          fails = 0;
  int          k = 0;
  int          snap = 0;
  logic [3:0]  m_an = '0;
  logic [6:0]  m_seg = '0;

  // Drive one cycle of inputs at the falling edge and queue the output expected after the next rising edge.
  // k counts enabled edges since reset; a frame is D*R of them and capture lands on its last edge.
  task automatic step(input logic r, input logic e, input logic b, input logic [15:0] v);
    int d;
    int dig;
    logic ft;
    @(negedge clk);
    rst = r; en = e; blank_lz = b; bcd_in = v;
    if (r) begin
      k = 0; snap = 0; m_an = '0; m_seg = '0;
      sb.push_back(12'h000);
    end else if (!e) begin
      sb.push_back({m_an, m_seg, 1'b0});
    end else begin
      d     = (k / R) % D;
      dig   = (snap >> (4 * d)) & 15;
      m_an  = 4'(1 << d);
      m_seg = (b && d >= 1 && (snap >> (4 * d)) == 0) ? 7'h00 : dec[dig];
      ft    = k > 0 && k % (D * R) == 0;
      if ((k + 1) % (D * R) == 0) snap = int'(v);
      k++;
      sb.push_back({m_an, m_seg, ft});
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every output sample is popped from the scoreboard and compared.
  initial begin
    logic [11:0] x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("an", int'(an), int'(x[11:8]));
        check("seg", int'(seg), int'(x[7:1]));
        check("frame_tick", int'(frame_tick), int'(x[0]));
      end
    end
  end

  initial begin
    repeat (2) step(1, 0, 0, 16'h0000);
    // Reset release and first frame, then a mid-frame input change
    repeat (22) step(0, 1, 0, 16'h1234);
    repeat (30) step(0, 1, 0, 16'h5678);
    // Leading-zero blanking, then blanking turned off live
    repeat (36) step(0, 1, 1, 16'h0040);
    repeat (10) step(0, 1, 0, 16'h0040);
    // Invalid code counts as non-zero
    repeat (36) step(0, 1, 1, 16'h00A0);
    // Freeze mid-digit
    repeat (2) step(0, 1, 0, 16'h9876);
    repeat (10) step(0, 0, 0, 16'h1111);
    repeat (24) step(0, 1, 0, 16'h9876);
    // Async reset between edges during digit 2
    for (int i = 0; i < 64 && !(((k / R) % D) == 2 && (k % R) == 1); i++) step(0, 1, 0, 16'h4321);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_seg", int'(seg), 0);
    check("rst_an", int'(an), 0);
    check("rst_ft", int'(frame_tick), 0);
    k = 0; snap = 0; m_an = '0; m_seg = '0;
    sb.push_back(12'h000);
    step(1, 0, 0, 16'h4321);
    repeat (40) step(0, 1, 1, 16'h4321);
    // Randomized stretch: random enable gaps, blanking and digit codes including invalid ones
    for (int i = 0; i < 600; i++)
      step(0, $urandom_range(9) != 0, 1'($urandom), 16'($urandom));
    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
